// File: rtl/vector_scalar_memory.sv
// Word-addressed vector data memory with element insert on store and pair-duplicate/extract formatting on load.
// One-cycle read latency, read-first on same-address write, one access per cycle, no backpressure.
module vector_scalar_memory #(
  parameter int ADDR_BITS = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] A,
  input  logic [31:0] WDV,
  input  logic [31:0] WDS,
  input  logic [1:0]  POS,
  input  logic        WE,
  input  logic        E,
  input  logic        S,
  output logic [31:0] RD
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [31:0]          mem [DEPTH];
  logic [ADDR_BITS-1:0] idx;
  logic [31:0]          wdata;

  logic [31:0] word_d, word_q;
  logic        s_d, s_q;
  logic        e_d, e_q;
  logic [1:0]  pos_d, pos_q;
  logic [31:0] rd_fmt;

  assign idx = A[ADDR_BITS-1:0];

  // Insert takes the other three elements from WDV, never from the old word.
  always_comb begin
    wdata = WDV;
    if (E) begin
      wdata[{POS, 3'b000} +: 8] = WDS[7:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (WE) begin
      mem[idx] <= wdata;
    end
  end

  always_comb begin
    word_d = mem[idx];
    s_d    = S;
    e_d    = E;
    pos_d  = POS;
  end

  // Clearing word_q along with the controls forces RD to zero during reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      word_q <= '0;
      s_q    <= 1'b0;
      e_q    <= 1'b0;
      pos_q  <= 2'b00;
    end else begin
      word_q <= word_d;
      s_q    <= s_d;
      e_q    <= e_d;
      pos_q  <= pos_d;
    end
  end

  always_comb begin
    rd_fmt = word_q;
    if (s_q) begin
      if (e_q) begin
        rd_fmt = {24'h0, word_q[{pos_q, 3'b000} +: 8]};
      end else if (pos_q[0]) begin
        rd_fmt = {word_q[31:24], word_q[31:24], word_q[23:16], word_q[23:16]};
      end else begin
        rd_fmt = {word_q[15:8], word_q[15:8], word_q[7:0], word_q[7:0]};
      end
    end
  end

  assign RD = rd_fmt;

endmodule

// File: tb/tb_vector_scalar_memory.sv
// Directed bench for vector_scalar_memory: store/load, insert, pair duplicate, extract, reset, read-first.
module tb_vector_scalar_memory;

  logic        CLK;
  logic        RST_N;
  logic [31:0] A;
  logic [31:0] WDV;
  logic [31:0] WDS;
  logic [1:0]  POS;
  logic        WE;
  logic        E;
  logic        S;
  logic [31:0] RD;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  vector_scalar_memory #(.ADDR_BITS(8)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .A    (A),
    .WDV  (WDV),
    .WDS  (WDS),
    .POS  (POS),
    .WE   (WE),
    .E    (E),
    .S    (S),
    .RD   (RD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic drive(input logic [31:0] a, input logic [31:0] wdv, input logic [31:0] wds,
                       input logic [1:0] pos, input logic we, input logic e, input logic s);
    A   = a;
    WDV = wdv;
    WDS = wds;
    POS = pos;
    WE  = we;
    E   = e;
    S   = s;
  endtask

  // One rising edge, then settle before sampling RD.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] exp);
    checks++;
    assert (RD === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: RD=%h expected %h", tag, RD, exp);
    end
  endtask

  initial begin
    RST_N = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    #12;
    check("reset_rd", 32'h0);
    RST_N = 1'b1;
    #2;

    // Vector stores A=5..9, WDV=A*10
    for (int i = 5; i <= 9; i++) begin
      drive(i, i * 10, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0);
      step();
    end
    drive(32'd5, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0); step(); check("load_5", 32'd50);
    drive(32'd6, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0); step(); check("load_6", 32'd60);
    drive(32'd7, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0); step(); check("load_7", 32'd70);
    drive(32'd8, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0); step(); check("load_8", 32'd80);
    drive(32'd9, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0); step(); check("load_9", 32'd90);

    // Address wrap: 0x105 and 0xFFFF_FF06 alias to words 5 and 6
    drive(32'h105, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0); step(); check("wrap_105", 32'd50);
    drive(32'hFFFF_FF06, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0); step(); check("wrap_hi", 32'd60);

    // Element insert into word 1
    drive(32'd1, 32'h03020100, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0); step();
    for (int p = 0; p < 4; p++) begin
      drive(32'd1, 32'h03020100, 32'hA, p[1:0], 1'b1, 1'b1, 1'b0);
      step();
    end
    drive(32'd1, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0); step(); check("insert_last", 32'h0a020100);
    // S=0 ignores E
    drive(32'd1, 32'h0, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0); step(); check("s0_e1_full", 32'h0a020100);

    // Pair duplicate
    drive(32'd1, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b1); step(); check("dup_pos0", 32'h01010000);
    drive(32'd1, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0, 1'b1); step(); check("dup_pos1", 32'h0a0a0202);
    drive(32'd1, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0, 1'b1); step(); check("dup_pos2", 32'h01010000);
    drive(32'd1, 32'h0, 32'h0, 2'd3, 1'b0, 1'b0, 1'b1); step(); check("dup_pos3", 32'h0a0a0202);

    // Extract
    drive(32'd1, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b1); step(); check("ext_pos0", 32'h0);
    drive(32'd1, 32'h0, 32'h0, 2'd1, 1'b0, 1'b1, 1'b1); step(); check("ext_pos1", 32'h1);
    drive(32'd1, 32'h0, 32'h0, 2'd2, 1'b0, 1'b1, 1'b1); step(); check("ext_pos2", 32'h2);
    drive(32'd1, 32'h0, 32'h0, 2'd3, 1'b0, 1'b1, 1'b1); step(); check("ext_pos3", 32'ha);

    // Reset asserted between edges clears RD at once
    drive(32'd8, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0); step(); check("pre_reset", 32'd80);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_reset", 32'h0);
    #3;
    RST_N = 1'b1;
    drive(32'd7, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0); step(); check("post_reset", 32'd70);

    // Read-during-write returns old contents
    drive(32'd3, 32'h11, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0); step();
    drive(32'd3, 32'h22, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0); step(); check("rdw_old", 32'h11);
    drive(32'd3, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0); step(); check("rdw_new", 32'h22);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vector_scalar_memory.md
Name: vector_scalar_memory

Overview:
- Single-port, word-addressed data memory for the vector ASIP datapath.
- Each 32-bit word is a vector of four 8-bit elements; element 0 is bits [7:0] and element 3 is bits [31:24].
- Supports full-vector store, single-element insert store, full-vector load, and two load-side formatting functions: element-pair duplication and scalar element extraction.
- Sits between the execute stage and the register files; RD is registered, giving one-cycle read latency.

Parameters:
- ADDR_BITS, 8, number of low-order bits of A used as the word index; depth = 2**ADDR_BITS words.

Ports:
- CLK    in   1   clock; all state updates on the rising edge.
- RST_N  in   1   asynchronous, active-low reset.
- A      in   32  word address; only A[ADDR_BITS-1:0] is used and the upper bits are ignored.
- WDV    in   32  vector write data (4 x 8-bit elements).
- WDS    in   32  scalar write data; only WDS[7:0] is used.
- POS    in   2   element position select.
- WE     in   1   write enable.
- E      in   1   element mode (store: insert one element; load with S=1: extract one element).
- S      in   1   special-load formatting enable.
- RD     out  32  registered read data.

Behaviour:
- Reset:
  - RST_N=0 asynchronously clears RD and the sampled control registers (s_q, e_q, pos_q) to 0.
  - Memory contents are not cleared by reset and are undefined after power-up.
- Write, on a rising edge with WE=1, to word A:
  - E=0: mem[A] <= WDV.
  - E=1: mem[A] <= WDV with element POS replaced by WDS[7:0]. The other three elements come from WDV, not from the old memory contents. There is no read-modify-write.
- Read: every rising edge (regardless of WE) captures word = mem[A] together with S, E and POS; RD is formed from these captured values.
- Read-during-write to the same address is read-first: RD returns the old contents.
- RD formatting, with b0..b3 the elements of the captured word:
  - S=0: RD = word (E ignored).
  - S=1, E=0 (pair duplicate):
    - POS[0]=0: RD = {b1,b1,b0,b0}.
    - POS[0]=1: RD = {b3,b3,b2,b2}.
    - POS[1] is ignored.
  - S=1, E=1 (extract): RD = {24'h0, b[POS]}.
- Latency: RD is valid one clock after A and the controls are presented; throughput is one access per cycle.
- RD holds its value only if A and the controls are unchanged; it is updated every edge.
- Address wrap: A values at or above 2**ADDR_BITS alias to A mod 2**ADDR_BITS.
- Reset asserted mid-operation: RD is forced to 0 immediately.
- If a write edge coincides with reset assertion, whether that write completes is unspecified; benches must not depend on it.

Test Plan:
- Vector store/load:
  - WE=1, E=0, S=0; write A=5..9 with WDV=A*10.
  - Then WE=0, read A=5..9 on successive edges -> RD = 50, 60, 70, 80, 90, each one cycle after the address is presented.
- Element insert:
  - WE=1, E=0, A=1, WDV=32'h03020100 for one edge.
  - Then E=1, WDS=32'hA, POS=0,1,2,3 on successive edges.
  - Then WE=0, E=0, S=0, one edge -> RD = 32'h0a020100 (last insert wins, other bytes from WDV).
- Pair duplicate:
  - With mem[1]=32'h0a020100, S=1, E=0.
  - POS=0 -> RD = 32'h01010000.
  - POS=1 -> RD = 32'h0a0a0202.
  - POS=2 -> 32'h01010000.
- Extract:
  - With mem[1]=32'h0a020100, S=1, E=1, WE=0.
  - POS=0..3 -> RD = 32'h0, 32'h1, 32'h2, 32'ha.
- Reset:
  - Assert RST_N=0 between clock edges -> RD = 0 immediately.
  - After release, a read of a previously written word returns its stored value.
- Read-during-write:
  - mem[3]=32'h11; WE=1, E=0, A=3, WDV=32'h22 -> RD = 32'h11 that cycle.
  - Next read of A=3 -> 32'h22.
